// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - LC-3 MAR/MDR memory cycle controller with SRAM port and device page
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   mio_en, r_w              access request (level) and direction (1 = write)
//   mar, mdr_wdata           access address and write data
//   rdata, ready             registered read data and one-cycle completion strobe (R)
//   sram_en, sram_we         one-cycle SRAM enable and its write qualifier
//   sram_addr, sram_wdata    SRAM address / write data, held after the access
//   sram_rdata               SRAM read data, valid the cycle after sram_en
//   kbd_data, kbd_valid      keyboard character side port
//   kbd_ack                  one-cycle pulse when a character is latched into KBDR
//   dsp_data, dsp_valid      display character side port
//   dsp_ready                display accepts the pending character
//   kbd_irq, dsp_irq         status-ready AND interrupt-enable for each device

module lc3_mem_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        sram_en,
  output logic        sram_we,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ack,
  output logic [7:0]  dsp_data,
  output logic        dsp_valid,
  input  logic        dsp_ready,
  output logic        kbd_irq,
  output logic        dsp_irq
);

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [7:0]  CNT_INIT  = 8'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        lat_we;
  logic        kbsr_rdy;
  logic        kbsr_ie;
  logic        dsr_ie;
  logic [7:0]  kbdr;

  logic        dev_access;
  logic        dev_rd;
  logic        dev_wr;
  logic        kbdr_rd;
  logic [15:0] dev_rdata;

  // Device accesses complete in the IDLE cycle that accepts them, so the
  // decode works on the live request rather than on latched copies.
  assign dev_access = (state == ST_IDLE) && mio_en && (mar[15:8] == 8'hFE);
  assign dev_rd     = dev_access && !r_w;
  assign dev_wr     = dev_access && r_w;
  assign kbdr_rd    = dev_rd && (mar == ADDR_KBDR);

  always_comb begin
    dev_rdata = 16'h0000;
    case (mar)
      ADDR_KBSR: dev_rdata = {kbsr_rdy, kbsr_ie, 14'b0};
      ADDR_KBDR: dev_rdata = {8'h00, kbdr};
      ADDR_DSR:  dev_rdata = {~dsp_valid, dsr_ie, 14'b0};
      ADDR_DDR:  dev_rdata = {8'h00, dsp_data};
      default:   dev_rdata = 16'h0000;
    endcase
  end

  assign kbd_irq = kbsr_rdy & kbsr_ie;
  assign dsp_irq = ~dsp_valid & dsr_ie;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      lat_we     <= 1'b0;
      rdata      <= 16'h0000;
      ready      <= 1'b0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= 16'h0000;
      sram_wdata <= 16'h0000;
      kbsr_rdy   <= 1'b0;
      kbsr_ie    <= 1'b0;
      dsr_ie     <= 1'b0;
      kbdr       <= 8'h00;
      kbd_ack    <= 1'b0;
      dsp_valid  <= 1'b0;
      dsp_data   <= 8'h00;
    end else begin
      ready   <= 1'b0;
      sram_en <= 1'b0;
      sram_we <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (mio_en) begin
            lat_we <= r_w;
            if (mar[15:8] == 8'hFE) begin
              if (!r_w) begin
                rdata <= dev_rdata;
              end
              ready <= 1'b1;
              state <= ST_DONE;
            end else begin
              sram_en    <= 1'b1;
              sram_we    <= r_w;
              sram_addr  <= mar;
              sram_wdata <= mdr_wdata;
              cnt        <= CNT_INIT;
              state      <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (cnt == 8'd0) begin
            if (!lat_we) begin
              rdata <= sram_rdata;
            end
            ready <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Keyboard: a KBDR read in flight suppresses latching on the same edge,
      // so the clear always wins and a held kbd_valid re-latches one cycle later.
      kbd_ack <= 1'b0;
      if (kbdr_rd) begin
        kbsr_rdy <= 1'b0;
      end else if (!kbsr_rdy && kbd_valid) begin
        kbdr     <= kbd_data;
        kbsr_rdy <= 1'b1;
        kbd_ack  <= 1'b1;
      end

      if (dev_wr && (mar == ADDR_KBSR)) begin
        kbsr_ie <= mdr_wdata[14];
      end
      if (dev_wr && (mar == ADDR_DSR)) begin
        dsr_ie <= mdr_wdata[14];
      end

      // Display: the DDR write sees the pre-edge dsp_valid, so a write that
      // coincides with the handshake is dropped rather than queued.
      if (dsp_valid && dsp_ready) begin
        dsp_valid <= 1'b0;
      end else if (dev_wr && (mar == ADDR_DDR) && !dsp_valid) begin
        dsp_data  <= mdr_wdata[7:0];
        dsp_valid <= 1'b1;
      end
    end
  end

endmodule
